regfile_init_wb: RTL and testbench
==================================

REGFILE_INIT_WB -- requirements
Module: regfile_init_wb

Interface
REQ-001 Parameter DATA_WIDTH, default 4: register data width in bits.
REQ-002 Parameter REG_WIDTH, default 5: register address width; the file holds 2**REG_WIDTH entries.
REQ-003 Parameter INIT_VALUE, default 0: value written to every entry during a sweep; truncated to DATA_WIDTH.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-006 in_valid  input  1  upstream write request valid.
REQ-007 in_ready  output  1  block accepts in_* this cycle.
REQ-008 in_addr  input  REG_WIDTH  upstream write address.
REQ-009 in_data  input  DATA_WIDTH  upstream write data.
REQ-010 clear_req  input  1  request re-initialisation of the whole register file.
REQ-011 wr_addr  output  REG_WIDTH  register-file write address.
REQ-012 wr_data  output  DATA_WIDTH  register-file write data.
REQ-013 wen  output  1  register-file write enable.
REQ-014 stall  output  1  high while sweeping; holds register-file read addresses.
REQ-015 busy  output  1  high while sweeping.
REQ-016 init_done  output  1  one-cycle pulse on the cycle after the last sweep write is issued.

Function
REQ-017 The block SHALL implement a two-state FSM: SWEEP and RUN, plus a REG_WIDTH-bit sweep counter cnt.
REQ-018 wr_addr, wr_data, wen and init_done SHALL be registered outputs; in_ready, stall and busy SHALL be combinational from state and clear_req.
REQ-019 In SWEEP, each edge SHALL load wen=1, wr_addr=cnt, wr_data=INIT_VALUE and increment cnt.
REQ-020 On the edge that loads wr_addr=2**REG_WIDTH-1, state SHALL become RUN and cnt SHALL wrap to 0; a sweep therefore takes exactly 2**REG_WIDTH edges, addresses in ascending order, none skipped or repeated.
REQ-021 init_done SHALL be 1 for exactly the one cycle in which the final sweep write (wr_addr=2**REG_WIDTH-1) is presented, and 0 otherwise.
REQ-022 busy and stall SHALL equal (state==SWEEP).
REQ-023 in_ready SHALL equal (state==RUN) and not clear_req.
REQ-024 In RUN, an edge with in_valid and in_ready SHALL load wen=1, wr_addr=in_addr, wr_data=in_data (latency one cycle); otherwise wen SHALL load 0 and wr_addr/wr_data SHALL hold.
REQ-025 In RUN, clear_req on an edge SHALL take priority: no upstream write accepted, wen loads 0, cnt loads 0, state becomes SWEEP; first sweep write appears one edge later.
REQ-026 A write accepted on the edge before clear_req SHALL still be presented (it is already registered) and is then overwritten by the sweep.
REQ-027 clear_req during SWEEP SHALL be ignored; the sweep SHALL not restart.
REQ-028 in_valid while in_ready=0 SHALL be ignored; upstream holds in_* until accepted.
REQ-029 Back-to-back accepted writes SHALL produce wen=1 on consecutive cycles with no bubble.

Reset
REQ-030 rst SHALL force state=SWEEP, cnt=0, wen=0, wr_addr=0, wr_data=0, init_done=0; busy=stall=1, in_ready=0 while rst asserted.
REQ-031 The first edge after rst deasserts SHALL present wen=1, wr_addr=0, wr_data=INIT_VALUE.
REQ-032 rst asserted mid-sweep or mid-RUN SHALL abort immediately and restart the sweep from address 0 after release.

Verification
REQ-033 Release rst, defaults -> wen=1 for 32 consecutive cycles, wr_addr 0..31, wr_data=0; init_done high only with wr_addr=31; in_ready=1 the following cycle.
REQ-034 After sweep, in_valid=1 for 3 cycles with (addr,data)=(3,0xA),(7,0x5),(3,0xF) -> wen=1 three consecutive cycles one cycle later with the same pairs; then wen=0.
REQ-035 In RUN, clear_req=1 together with in_valid=1 (addr 9) -> in_ready=0, no write to 9; next edge starts sweep at wr_addr=0; full 32-write sweep follows; clear_req pulsed at sweep cycle 10 has no effect.
REQ-036 Assert rst at sweep cycle 17 for one cycle -> wen=0 during reset, sweep restarts at wr_addr=0 and completes 32 writes.
REQ-037 INIT_VALUE=0x6, REG_WIDTH=3 -> 8 sweep writes of 0x6 to addresses 0..7, init_done on wr_addr=7.
REQ-038 Downstream register-file model with read on stall=0 only -> after sweep every read returns INIT_VALUE until overwritten; written entries read back the last written data.

Source files
------------

// File: rtl/regfile_init_wb_if.sv
// Upstream write-request channel of regfile_init_wb.
//   in_valid : request valid                (master -> slave)
//   in_addr  : register address             (master -> slave)
//   in_data  : register data                (master -> slave)
//   in_ready : request accepted this cycle  (slave  -> master)
interface regfile_init_wb_if #(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned REG_WIDTH  = 5
) ();
   logic                  in_valid;
   logic                  in_ready;
   logic [REG_WIDTH-1:0]  in_addr;
   logic [DATA_WIDTH-1:0] in_data;

   modport master (output in_valid, output in_addr, output in_data, input in_ready);
   modport slave  (input in_valid, input in_addr, input in_data, output in_ready);
endinterface

// File: rtl/regfile_init_wb.sv
// Register-file write-port front end with an initialisation sweep.
// After reset, or on clear_req while running, every entry is written with
// INIT_VALUE in ascending address order. Otherwise upstream writes pass
// through with one cycle of latency.
//   clk, rst  : clock, synchronous active-high reset
//   up        : upstream write request channel (slave side)
//   clear_req : request a new sweep (ignored while one is in progress)
//   wr_addr, wr_data, wen : registered register-file write port
//   stall, busy           : high while sweeping (combinational)
//   init_done             : registered pulse alongside the final sweep write
module regfile_init_wb #(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned REG_WIDTH  = 5,
   parameter int unsigned INIT_VALUE = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   regfile_init_wb_if.slave      up,
   input  logic                  clear_req,
   output logic [REG_WIDTH-1:0]  wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wen,
   output logic                  stall,
   output logic                  busy,
   output logic                  init_done
);

   localparam logic [DATA_WIDTH-1:0] INIT_DATA = DATA_WIDTH'(INIT_VALUE);
   localparam logic [REG_WIDTH-1:0]  LAST_ADDR = '1;

   typedef enum logic {
      ST_SWEEP = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t                state_q;
   logic [REG_WIDTH-1:0]  cnt_q;
   logic [REG_WIDTH-1:0]  wr_addr_q;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic                  wen_q;
   logic                  init_done_q;

   // Combinational status and handshake, a function of state and clear_req only
   assign busy        = (state_q == ST_SWEEP);
   assign stall       = (state_q == ST_SWEEP);
   assign up.in_ready = (state_q == ST_RUN) && !clear_req;

   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign wen       = wen_q;
   assign init_done = init_done_q;

   // FSM, sweep counter and registered write port
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_SWEEP;
         cnt_q       <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wen_q       <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         init_done_q <= 1'b0;
         case (state_q)
            ST_SWEEP: begin
               // clear_req and upstream requests are not looked at here
               wen_q       <= 1'b1;
               wr_addr_q   <= cnt_q;
               wr_data_q   <= INIT_DATA;
               cnt_q       <= cnt_q + REG_WIDTH'(1);
               init_done_q <= (cnt_q == LAST_ADDR);
               if (cnt_q == LAST_ADDR) begin
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (clear_req) begin
                  // Clear wins over a simultaneous request
                  wen_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= ST_SWEEP;
               end else if (up.in_valid) begin
                  wen_q     <= 1'b1;
                  wr_addr_q <= up.in_addr;
                  wr_data_q <= up.in_data;
               end else begin
                  wen_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_SWEEP;
               cnt_q   <= '0;
               wen_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_init_wb.sv
// Bench for regfile_init_wb: a main instance (defaults) checked every cycle
// against a transaction-level model, a small REG_WIDTH=3 / INIT_VALUE=6
// instance checked directly, and a downstream register file read back while
// stall is low.
module tb_regfile_init_wb;

   localparam int N  = 32;
   localparam int N8 = 8;

   logic clk = 1'b0;
   logic rst;
   logic clear_req;
   logic clear8;
   always #5 clk = ~clk;

   logic [4:0] wr_addr;
   logic [3:0] wr_data;
   logic       wen, stall, busy, init_done;
   logic [2:0] wr_addr8;
   logic [3:0] wr_data8;
   logic       wen8, stall8, busy8, done8;

   regfile_init_wb_if #(.DATA_WIDTH(4), .REG_WIDTH(5)) up_if ();
   regfile_init_wb_if #(.DATA_WIDTH(4), .REG_WIDTH(3)) up8 ();

   regfile_init_wb #(.DATA_WIDTH(4), .REG_WIDTH(5), .INIT_VALUE(0)) dut (
      .clk(clk), .rst(rst), .up(up_if), .clear_req(clear_req),
      .wr_addr(wr_addr), .wr_data(wr_data), .wen(wen),
      .stall(stall), .busy(busy), .init_done(init_done)
   );

   regfile_init_wb #(.DATA_WIDTH(4), .REG_WIDTH(3), .INIT_VALUE(6)) dut8 (
      .clk(clk), .rst(rst), .up(up8), .clear_req(clear8),
      .wr_addr(wr_addr8), .wr_data(wr_data8), .wen(wen8),
      .stall(stall8), .busy(busy8), .init_done(done8)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: actual=0x%0h required=0x%0h", name, $time, act, exp);
      end
   endtask

   // Behavioural model: a sweep is "N writes still owed"; otherwise pass-through
   int         sweep_left = 0;
   bit         mvalid = 1'b0;
   logic       exp_wen, exp_done;
   logic [4:0] exp_addr;
   logic [3:0] exp_data;
   logic [3:0] emem [N];
   logic [3:0] dmem [N];

   always @(posedge clk) begin
      if (mvalid && exp_wen) emem[exp_addr] = exp_data;
      exp_done = 1'b0;
      if (rst) begin
         sweep_left = N;
         exp_wen    = 1'b0;
         exp_addr   = '0;
         exp_data   = '0;
         mvalid     = 1'b1;
      end else if (mvalid) begin
         if (sweep_left > 0) begin
            exp_wen    = 1'b1;
            exp_addr   = 5'(N - sweep_left);
            exp_data   = 4'h0;
            exp_done   = (sweep_left == 1);
            sweep_left = sweep_left - 1;
         end else if (clear_req) begin
            sweep_left = N;
            exp_wen    = 1'b0;
         end else if (up_if.in_valid) begin
            exp_wen  = 1'b1;
            exp_addr = up_if.in_addr;
            exp_data = up_if.in_data;
         end else begin
            exp_wen = 1'b0;
         end
      end
   end

   // Cycle-by-cycle compare against the model
   always @(negedge clk) begin
      if (mvalid) begin
         chk("m_wen",      32'(wen),            32'(exp_wen));
         chk("m_wr_addr",  32'(wr_addr),        32'(exp_addr));
         chk("m_wr_data",  32'(wr_data),        32'(exp_data));
         chk("m_done",     32'(init_done),      32'(exp_done));
         chk("m_busy",     32'(busy),           32'(sweep_left > 0));
         chk("m_stall",    32'(stall),          32'(sweep_left > 0));
         chk("m_in_ready", 32'(up_if.in_ready), 32'((sweep_left == 0) && !clear_req));
      end
   end

   // Downstream register file written by the DUT, read only while stall is low
   always @(posedge clk) begin
      if (wen === 1'b1) dmem[wr_addr] <= wr_data;
   end

   logic [4:0] raddr = '0;
   always @(negedge clk) begin
      if (mvalid && stall === 1'b0) begin
         if (!$isunknown(emem[raddr])) chk("readback", 32'(dmem[raddr]), 32'(emem[raddr]));
         raddr = raddr + 5'd1;
      end
   end

   task automatic set_in(input logic v, input logic [4:0] a, input logic [3:0] d, input logic c);
      #1;
      up_if.in_valid = v;
      up_if.in_addr  = a;
      up_if.in_data  = d;
      clear_req      = c;
   endtask

   task automatic sweep_check(input string tag);
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         chk({tag, "_wen"},  32'(wen),       32'd1);
         chk({tag, "_addr"}, 32'(wr_addr),   32'(i));
         chk({tag, "_data"}, 32'(wr_data),   32'd0);
         chk({tag, "_done"}, 32'(init_done), 32'(i == N - 1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      clear_req = 1'b0;
      clear8 = 1'b0;
      up_if.in_valid = 1'b0; up_if.in_addr = '0; up_if.in_data = '0;
      up8.in_valid = 1'b0;   up8.in_addr = '0;   up8.in_data = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_wen",   32'(wen),            32'd0);
      chk("rst_addr",  32'(wr_addr),        32'd0);
      chk("rst_busy",  32'(busy),           32'd1);
      chk("rst_stall", 32'(stall),          32'd1);
      chk("rst_ready", 32'(up_if.in_ready), 32'd0);
      chk("rst_done8", 32'(done8),          32'd0);
      #1 rst = 1'b0;

      // Power-up sweep on both instances
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         chk("sw0_addr", 32'(wr_addr),   32'(i));
         chk("sw0_wen",  32'(wen),       32'd1);
         chk("sw0_data", 32'(wr_data),   32'd0);
         chk("sw0_done", 32'(init_done), 32'(i == N - 1));
         if (i < N8) begin
            chk("sw8_wen",  32'(wen8),     32'd1);
            chk("sw8_addr", 32'(wr_addr8), 32'(i));
            chk("sw8_data", 32'(wr_data8), 32'h6);
            chk("sw8_done", 32'(done8),    32'(i == N8 - 1));
         end else if (i == N8) begin
            chk("run8_wen",   32'(wen8),         32'd0);
            chk("run8_ready", 32'(up8.in_ready), 32'd1);
            chk("run8_done",  32'(done8),        32'd0);
         end
      end
      chk("run_ready", 32'(up_if.in_ready), 32'd1);
      chk("run_busy",  32'(busy),           32'd0);

      // Three back-to-back writes
      set_in(1'b1, 5'd3, 4'hA, 1'b0);
      @(negedge clk);
      chk("b2b0", {wen, 3'b0, wr_addr, wr_data}, {1'b1, 3'b0, 5'd3, 4'hA});
      set_in(1'b1, 5'd7, 4'h5, 1'b0);
      @(negedge clk);
      chk("b2b1", {wen, 3'b0, wr_addr, wr_data}, {1'b1, 3'b0, 5'd7, 4'h5});
      set_in(1'b1, 5'd3, 4'hF, 1'b0);
      @(negedge clk);
      chk("b2b2", {wen, 3'b0, wr_addr, wr_data}, {1'b1, 3'b0, 5'd3, 4'hF});
      set_in(1'b0, 5'd0, 4'h0, 1'b0);
      @(negedge clk);
      chk("b2b_end", {wen, 3'b0, wr_addr, wr_data}, {1'b0, 3'b0, 5'd3, 4'hF});
      repeat (36) @(negedge clk);
      chk("rf3", 32'(dmem[3]), 32'hF);
      chk("rf7", 32'(dmem[7]), 32'h5);
      chk("rf0", 32'(dmem[0]), 32'h0);

      // Write then clear together with a request to address 9
      set_in(1'b1, 5'd5, 4'h3, 1'b0);
      @(negedge clk);
      chk("pre_clr", {wen, 3'b0, wr_addr, wr_data}, {1'b1, 3'b0, 5'd5, 4'h3});
      set_in(1'b1, 5'd9, 4'hC, 1'b1);
      #1;
      chk("clr_ready", 32'(up_if.in_ready), 32'd0);
      @(negedge clk);
      chk("clr_wen",  32'(wen),  32'd0);
      chk("clr_busy", 32'(busy), 32'd1);
      set_in(1'b0, 5'd0, 4'h0, 1'b0);
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         chk("sw1_addr", 32'(wr_addr), 32'(i));
         chk("sw1_wen",  32'(wen),     32'd1);
         if (i == 10) set_in(1'b0, 5'd0, 4'h0, 1'b1);
         if (i == 11) set_in(1'b1, 5'd9, 4'hC, 1'b0);
         if (i == 20) set_in(1'b0, 5'd0, 4'h0, 1'b0);
      end
      @(negedge clk);
      chk("sw1_end_wen", 32'(wen), 32'd0);
      repeat (34) @(negedge clk);
      chk("rf9", 32'(dmem[9]), 32'h0);
      chk("rf5", 32'(dmem[5]), 32'h0);
      chk("rf3b", 32'(dmem[3]), 32'h0);

      // Reset in the middle of a sweep
      set_in(1'b0, 5'd0, 4'h0, 1'b1);
      @(negedge clk);
      chk("sw2_start", 32'(busy), 32'd1);
      set_in(1'b0, 5'd0, 4'h0, 1'b0);
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         chk("sw2_addr", 32'(wr_addr), 32'(i));
      end
      #1 rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_wen",   32'(wen),            32'd0);
      chk("mid_rst_addr",  32'(wr_addr),        32'd0);
      chk("mid_rst_busy",  32'(busy),           32'd1);
      chk("mid_rst_ready", 32'(up_if.in_ready), 32'd0);
      #1 rst = 1'b0;
      sweep_check("sw3");

      // Final write and readback
      set_in(1'b1, 5'd12, 4'h9, 1'b0);
      @(negedge clk);
      set_in(1'b0, 5'd0, 4'h0, 1'b0);
      repeat (34) @(negedge clk);
      chk("rf12", 32'(dmem[12]), 32'h9);
      chk("rf31", 32'(dmem[31]), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
